// File: rtl/mult_pkg.sv
// Shared constants for the shift-and-add multiplier: controller state encoding
// and the default operand width.
package mult_pkg;

  localparam int WIDTH_DEF = 16;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_CALC = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

endpackage

// File: rtl/seq_mult_shift_add_if.sv
// Request/response bundle between a controlling master and the multiplier.
interface seq_mult_shift_add_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, signed_mode, a_in, b_in,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a_in, b_in,
    output busy, done, product
  );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Controller: IDLE -> CALC (one multiplier bit per cycle) -> DONE -> IDLE.
module seq_mult_ctrl
  import mult_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic last,
  output logic load,
  output logic step,
  output logic busy,
  output logic done
);

  logic [1:0] state, state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // start is only honoured in IDLE, so requests during CALC/DONE are dropped
  assign load = (state == S_IDLE) && start;
  assign step = (state == S_CALC);
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: rtl/seq_mult_datapath.sv
// Datapath: operand magnitude capture, mcand/mplier shift registers,
// accumulator and final sign fix-up into the product register.
module seq_mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
  logic [WIDTH-1:0]   mplier, a_mag, b_mag, a_neg, b_neg;
  logic               sgn, neg;

  assign sgn   = signed_mode & SIGNED_EN;
  assign a_neg = ~a + 1'b1;
  assign b_neg = ~b + 1'b1;
  // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude
  assign a_mag = (sgn && a[WIDTH-1]) ? a_neg : a;
  assign b_mag = (sgn && b[WIDTH-1]) ? b_neg : b;

  assign acc_nxt = mplier[0] ? acc + mcand : acc;
  // early exit: nothing left to add once the shifted multiplier is zero
  assign last    = (mplier[WIDTH-1:1] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      acc    <= '0;
      neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (last) product <= neg ? (~acc_nxt + 1'b1) : acc_nxt;
    end
  end

endmodule

// File: rtl/seq_mult_shift_add.sv
// Sequential shift-and-add multiplier with signed/unsigned mode and a
// start/busy/done handshake; full 2*WIDTH product.
module seq_mult_shift_add
  import mult_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  seq_mult_shift_add_if.slave bus
);

  logic load, step, last;

  seq_mult_ctrl u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .start (bus.start),
    .last  (last),
    .load  (load),
    .step  (step),
    .busy  (bus.busy),
    .done  (bus.done)
  );

  seq_mult_datapath #(
    .WIDTH     (WIDTH),
    .SIGNED_EN (SIGNED_EN)
  ) u_dp (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (step),
    .signed_mode (bus.signed_mode),
    .a           (bus.a_in),
    .b           (bus.b_in),
    .last        (last),
    .product     (bus.product)
  );

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Directed bench for seq_mult_shift_add (WIDTH=16): products, latency,
// busy/done timing, ignored restarts and mid-operation reset.
module tb_seq_mult_shift_add;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  seq_mult_shift_add_if #(.WIDTH(16)) bus ();

  seq_mult_shift_add #(.WIDTH(16), .SIGNED_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request; latency exp_n is counted in edges from accept to DONE entry.
  // With inject set, start stays high through the whole busy window.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sm, input logic [31:0] exp_p, input int exp_n,
                        input bit inject);
    logic [31:0] prev;
    int k, busy_cnt, d0;
    bit seen;
    @(negedge clk);
    prev = bus.product;
    d0   = done_cnt;
    bus.start = 1'b1; bus.a_in = a; bus.b_in = b; bus.signed_mode = sm;
    seen = 0; busy_cnt = 0; k = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      bus.start = inject;
      bus.a_in = 16'($urandom); bus.b_in = 16'($urandom); bus.signed_mode = 1'($urandom);
      if (k == 1) check({tag, "_held"}, 64'(bus.product), 64'(prev));
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) seen = 1;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(k - 1), 64'(exp_n));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_n + 1));
    check({tag, "_product"}, 64'(bus.product), 64'(exp_p));
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_idle_done"}, 64'(bus.done), 64'd0);
    if (inject) begin
      repeat (5) @(negedge clk);
      check({tag, "_no_restart"}, 64'(bus.busy), 64'd0);
    end
    check({tag, "_one_done"}, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int d0;
    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.a_in = '0; bus.b_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_product", 64'(bus.product), 64'd0);
    rst = 1'b0;

    run_op("u3x5",     16'd3,      16'd5,      1'b0, 32'h0000000F, 3,  1'b0);
    run_op("uffxff",   16'hFFFF,   16'hFFFF,   1'b0, 32'hFFFE0001, 16, 1'b0);
    run_op("s_m3x7",   16'hFFFD,   16'd7,      1'b1, 32'hFFFFFFEB, 3,  1'b0);
    run_op("s_min2",   16'h8000,   16'h8000,   1'b1, 32'h40000000, 16, 1'b0);
    run_op("u_8000sq", 16'h8000,   16'h8000,   1'b0, 32'h40000000, 16, 1'b0);
    run_op("u1234x0",  16'd1234,   16'd0,      1'b0, 32'h00000000, 1,  1'b1);
    run_op("s7xm1",    16'd7,      16'hFFFF,   1'b1, 32'hFFFFFFF9, 1,  1'b0);
    run_op("u1x1",     16'd1,      16'd1,      1'b0, 32'h00000001, 1,  1'b0);

    // Reset in the fifth CALC cycle abandons the operation
    @(negedge clk);
    d0 = done_cnt;
    bus.start = 1'b1; bus.a_in = 16'hFFFF; bus.b_in = 16'hFFFF; bus.signed_mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy_before_rst", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_product", 64'(bus.product), 64'd0);
    repeat (20) @(negedge clk);
    check("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);

    run_op("after_rst", 16'd300,   16'd200,    1'b0, 32'd60000,    8,  1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
